// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bundle for the shared sprite ROM: request/address in, grant and
// tagged response out.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 16
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req, req_addr,
    input  gnt, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_addr,
    output gnt, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-read sprite ROM among NUM_REQ requesters: one grant per cycle,
// optional fixed priority for requester 0, responses routed back by a one-hot id pipe.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 1,
  parameter int HI_PRI0 = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  sprite_rom_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic                busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t               rr_ptr;
  ptr_t               rr_ptr_nxt;
  ptr_t               gnt_idx;
  ptr_t               cand;
  logic               gnt_any;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] stage [ROM_LAT];
  logic [DATA_W-1:0]  data_q;
  logic               rsp_any;

  function automatic ptr_t wrap_add(ptr_t p, int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ptr_t'(s);
  endfunction

  // No grant is issued while reset is asserted, even with requests pending.
  always_comb begin
    gnt        = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    cand       = '0;
    rr_ptr_nxt = rr_ptr;
    if (reset_n) begin
      if (HI_PRI0 != 0 && bus.req[0]) begin
        gnt_any = 1'b1;
        gnt_idx = '0;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = wrap_add(rr_ptr, k);
          if (!gnt_any && bus.req[cand] && !(HI_PRI0 != 0 && cand == '0)) begin
            gnt_any    = 1'b1;
            gnt_idx    = cand;
            rr_ptr_nxt = cand;
          end
        end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
    end
  end

  assign bus.gnt  = gnt;
  assign rom_addr = gnt_any ? bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= ptr_t'(NUM_REQ - 1);
      for (int k = 0; k < ROM_LAT; k++) stage[k] <= '0;
      data_q <= '0;
    end else begin
      rr_ptr   <= rr_ptr_nxt;
      stage[0] <= gnt;
      for (int k = 1; k < ROM_LAT; k++) stage[k] <= stage[k-1];
      if (rsp_any) data_q <= rom_data;
    end
  end

  // The ROM word is live in the same cycle the id leaves the pipe; hold it afterwards.
  assign rsp_any       = |stage[ROM_LAT-1];
  assign bus.rsp_valid = stage[ROM_LAT-1];
  assign bus.rsp_data  = rsp_any ? rom_data : data_q;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < ROM_LAT; k++) busy = busy | (|stage[k]);
  end

endmodule
